// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone B3 arbiter sharing one slave port
// between NUM_MASTERS masters. A grant lasts for the winner's whole cyc
// assertion, so bursts and locked sequences are never split.
// Optional bus watchdog: define WB_ARB_TIMEOUT_EN to enable it.
module wb_rr_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    // master side
    input  logic [NUM_MASTERS*AW-1:0]     m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]     m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0]   m_sel_i,
    input  logic [NUM_MASTERS-1:0]        m_we_i,
    input  logic [NUM_MASTERS-1:0]        m_cyc_i,
    input  logic [NUM_MASTERS-1:0]        m_stb_i,
    input  logic [NUM_MASTERS*3-1:0]      m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]      m_bte_i,
    output logic [DW-1:0]                 m_dat_o,
    output logic [NUM_MASTERS-1:0]        m_ack_o,
    output logic [NUM_MASTERS-1:0]        m_err_o,
    // slave side
    output logic [AW-1:0]                 s_adr_o,
    output logic [DW-1:0]                 s_dat_o,
    output logic [DW/8-1:0]               s_sel_o,
    output logic                          s_we_o,
    output logic                          s_cyc_o,
    output logic                          s_stb_o,
    output logic [2:0]                    s_cti_o,
    output logic [1:0]                    s_bte_o,
    input  logic [DW-1:0]                 s_dat_i,
    input  logic                          s_ack_i,
    input  logic                          s_err_i,
    // status
    output logic [NUM_MASTERS-1:0]        grant_o
);

    localparam int SW = DW / 8;
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = IW + 1;

    // Elaboration-time parameter sanity checks.
    if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
        $error("wb_rr_arbiter: NUM_MASTERS must be in 2..8");
    end
    if ((DW % 8) != 0) begin : g_bad_dw
        $error("wb_rr_arbiter: DW must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("wb_rr_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;          // round-robin search start
    logic [IW-1:0] gnt_idx_q, gnt_idx_d;  // index of the granted master

    logic          busy;
    logic          g_cyc;
    logic          g_stb;
    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [CW-1:0] cand_w;
    logic [IW-1:0] cand;
    logic [IW-1:0] next_ptr;

    // Watchdog hooks: slave_off gates the slave bus, err_gen injects an err.
    logic          slave_off;
    logic          err_gen;

    assign busy  = (state_q == ST_BUSY);
    assign g_cyc = m_cyc_i[gnt_idx_q];
    assign g_stb = m_stb_i[gnt_idx_q];

    // Pointer after the current tenure, wrapping explicitly at NUM_MASTERS-1
    // because NUM_MASTERS need not be a power of two.
    assign next_ptr = (gnt_idx_q == IW'(NUM_MASTERS - 1)) ? '0 : gnt_idx_q + 1'b1;

    // Round-robin winner search: first cyc found from ptr_q upward, with wrap.
    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_w    = '0;
        cand      = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand_w = {1'b0, ptr_q} + CW'(k);
            if (cand_w >= CW'(NUM_MASTERS)) begin
                cand_w = cand_w - CW'(NUM_MASTERS);
            end
            cand = cand_w[IW-1:0];
            if (!win_found && m_cyc_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state logic: grant on any cyc, release when the granted cyc drops.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d   = ST_BUSY;
                    gnt_idx_d = win_idx;
                end
            end
            ST_BUSY: begin
                // An IDLE cycle always follows, so hand-over is never back-to-back.
                if (!g_cyc) begin
                    state_d = ST_IDLE;
                    ptr_d   = next_ptr;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer and grant registers.
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of the order the simulator runs these blocks.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          timed_out_q, timed_out_d;
    logic          stb_pend;
    logic          to_hit;

    // A strobe is outstanding towards the slave and not yet given up on.
    assign stb_pend = busy & g_cyc & g_stb & ~timed_out_q;
    // The hit depends only on registered state and master inputs, never on
    // s_ack_i, so a combinational slave ack cannot form a loop through s_stb_o.
    assign to_hit   = stb_pend & (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Watchdog next state: count stalled strobe cycles, latch the timeout
    // until the granted master releases cyc.
    always_comb begin
        to_cnt_d    = to_cnt_q;
        timed_out_d = timed_out_q;
        if (!busy || !g_cyc) begin
            to_cnt_d    = '0;
            timed_out_d = 1'b0;
        end else if (to_hit) begin
            to_cnt_d    = '0;
            timed_out_d = 1'b1;
        end else if (s_ack_i || s_err_i) begin
            to_cnt_d    = '0;
        end else if (stb_pend) begin
            to_cnt_d    = to_cnt_q + 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            to_cnt_q    <= '0;
            timed_out_q <= 1'b0;
        end else begin
            to_cnt_q    <= to_cnt_d;
            timed_out_q <= timed_out_d;
        end
    end

    // From the timeout cycle on the slave bus is dead, so a late ack is lost.
    assign slave_off = timed_out_q | to_hit;
    assign err_gen   = to_hit;
`else
    // Without the watchdog a hung slave stalls the granted master forever.
    assign slave_off = 1'b0;
    assign err_gen   = 1'b0;
`endif

    // Output muxing: slave bus follows the granted master, responses are
    // steered back to it only; everything is zero while idle.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        grant_o = '0;
        if (busy) begin
            grant_o[gnt_idx_q] = 1'b1;
            if (!slave_off) begin
                s_adr_o            = m_adr_i[gnt_idx_q*AW +: AW];
                s_dat_o            = m_dat_i[gnt_idx_q*DW +: DW];
                s_sel_o            = m_sel_i[gnt_idx_q*SW +: SW];
                s_we_o             = m_we_i[gnt_idx_q];
                s_cti_o            = m_cti_i[gnt_idx_q*3 +: 3];
                s_bte_o            = m_bte_i[gnt_idx_q*2 +: 2];
                // cyc tracks the master combinationally so it falls with it.
                s_cyc_o            = g_cyc;
                s_stb_o            = g_stb & g_cyc;
                m_ack_o[gnt_idx_q] = s_ack_i;
                m_err_o[gnt_idx_q] = s_err_i;
            end
            if (err_gen) begin
                m_err_o[gnt_idx_q] = 1'b1;
            end
        end
    end

    // Read data is broadcast; only the acked master latches it.
    assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed scenarios plus a randomized run, every cycle
// checked against a behavioural round-robin model. Build with
// WB_ARB_TIMEOUT_EN defined to exercise the watchdog variant.
module tb_wb_rr_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [N*SW-1:0] m_sel;
    logic [N-1:0]    m_we, m_cyc, m_stb;
    logic [N*3-1:0]  m_cti;
    logic [N*2-1:0]  m_bte;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack_o, m_err_o, grant_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic            s_we_o, s_cyc_o, s_stb_o;
    logic [2:0]      s_cti_o;
    logic [1:0]      s_bte_o;
    logic [DW-1:0]   s_dat;
    logic            s_ack, s_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state.
    bit md_busy;
    int md_g;
    int md_ptr;
    int md_wait;
    bit md_to;
    bit md_hit;

    always #5 clk = ~clk;

    wb_rr_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i(clk),     .wb_rst_i(rst),
        .m_adr_i(m_adr),    .m_dat_i(m_dat),   .m_sel_i(m_sel), .m_we_i(m_we),
        .m_cyc_i(m_cyc),    .m_stb_i(m_stb),   .m_cti_i(m_cti), .m_bte_i(m_bte),
        .m_dat_o(m_dat_o),  .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_adr_o(s_adr_o),  .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o),  .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat),    .s_ack_i(s_ack),   .s_err_i(s_err),
        .grant_o(grant_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        md_busy = 0;
        md_g    = 0;
        md_ptr  = 0;
        md_wait = 0;
        md_to   = 0;
        md_hit  = 0;
    endtask

    // Compare every DUT output with what the model predicts for this cycle.
    task automatic check_model();
        logic [N-1:0]  e_gnt, e_ack, e_err;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_sel;
        logic [2:0]    e_cti;
        logic [1:0]    e_bte;
        logic          e_we, e_cyc, e_stb;
        bit            live, hit;
        e_gnt = '0; e_ack = '0; e_err = '0; e_adr = '0; e_dat = '0; e_sel = '0;
        e_cti = '0; e_bte = '0; e_we = 0; e_cyc = 0; e_stb = 0;
        hit = 0;
        if (md_busy) begin
            e_gnt[md_g] = 1'b1;
            live = !md_to;
`ifdef WB_ARB_TIMEOUT_EN
            hit = live && m_cyc[md_g] && m_stb[md_g] && (md_wait == TO - 1);
`endif
            if (live && !hit) begin
                e_adr = m_adr[md_g*AW +: AW];
                e_dat = m_dat[md_g*DW +: DW];
                e_sel = m_sel[md_g*SW +: SW];
                e_cti = m_cti[md_g*3 +: 3];
                e_bte = m_bte[md_g*2 +: 2];
                e_we  = m_we[md_g];
                e_cyc = m_cyc[md_g];
                e_stb = m_cyc[md_g] && m_stb[md_g];
                e_ack[md_g] = s_ack;
                e_err[md_g] = s_err;
            end
            if (hit) e_err[md_g] = 1'b1;
        end
        md_hit = hit;
        check("grant",  grant_o, e_gnt);
        check("s_cyc",  s_cyc_o, e_cyc);
        check("s_stb",  s_stb_o, e_stb);
        check("s_adr",  s_adr_o, e_adr);
        check("s_dat",  s_dat_o, e_dat);
        check("s_sel",  s_sel_o, e_sel);
        check("s_we",   s_we_o,  e_we);
        check("s_cti",  s_cti_o, e_cti);
        check("s_bte",  s_bte_o, e_bte);
        check("m_ack",  m_ack_o, e_ack);
        check("m_err",  m_err_o, e_err);
        check("m_dat",  m_dat_o, s_dat);
    endtask

    // Advance the model across one clock edge using the held inputs.
    task automatic model_edge();
        bit found;
        int c;
        if (!md_busy) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                c = (md_ptr + k) % N;
                if (!found && m_cyc[c]) begin
                    found   = 1;
                    md_busy = 1;
                    md_g    = c;
                end
            end
        end else if (!m_cyc[md_g]) begin
            md_busy = 0;
            md_ptr  = (md_g + 1) % N;
            md_wait = 0;
            md_to   = 0;
        end else begin
`ifdef WB_ARB_TIMEOUT_EN
            if (md_hit) begin
                md_to   = 1;
                md_wait = 0;
            end else if (s_ack || s_err) begin
                md_wait = 0;
            end else if (!md_to && m_stb[md_g]) begin
                md_wait++;
            end
`endif
        end
    endtask

    // Called at a falling edge with inputs set: check, take the edge, return
    // at the next falling edge.
    task automatic step();
        #1;
        check_model();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
        m_cti = '0; m_bte = '0; s_dat = '0; s_ack = 0; s_err = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        check("rst_grant", grant_o, 0);
        check("rst_s_cyc", s_cyc_o, 0);
        check("rst_ack",   m_ack_o, 0);
        check("rst_err",   m_err_o, 0);
        rst = 0;
        model_reset();
        @(negedge clk);
    endtask

    // Watchdog against a hung bench or DUT.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acks0, acks1, seen, prev_gnt, idx, errs, first_err, bad_cyc, n_cycles;
        int seq [6];
        logic [N-1:0] acked;

        rst = 1;
        clear_inputs();
        model_reset();
        do_reset();

        // Single master: M1 writes 0xDEADBEEF to 0x100, slave acks after 3 cycles.
        m_cyc[1] = 1; m_stb[1] = 1; m_we[1] = 1;
        m_adr[1*AW +: AW] = 32'h0000_0100;
        m_dat[1*DW +: DW] = 32'hDEAD_BEEF;
        m_sel[1*SW +: SW] = 4'hF;
        #1;
        check("t2_cyc_lat", s_cyc_o, 0);
        step();
        #1;
        check("t2_cyc_up", s_cyc_o, 1);
        check("t2_adr", s_adr_o, 32'h0000_0100);
        check("t2_dat", s_dat_o, 32'hDEAD_BEEF);
        check("t2_grant", grant_o, 3'b010);
        acks0 = 0;
        for (int i = 0; i < 3; i++) begin
            acks0 += int'(m_ack_o[0]);
            check("t2_wait_ack", m_ack_o, 0);
            step();
        end
        s_ack = 1;
        #1;
        check("t2_ack", m_ack_o, 3'b010);
        acks0 += int'(m_ack_o[0]);
        step();
        m_cyc[1] = 0; m_stb[1] = 0; s_ack = 0;
        #1;
        check("t2_cyc_fall", s_cyc_o, 0);
        check("t2_no_ack0", acks0, 0);
        step();
        step();

        // Reset mid-transfer: pointer was moved by M1, must return to 0.
        m_cyc[0] = 1; m_stb[0] = 1;
        step();
        m_cyc[2] = 1; m_stb[2] = 1; s_ack = 1;
        #1;
        check("t1_grant", grant_o, 3'b001);
        check("t1_ack", m_ack_o, 3'b001);
        #1 rst = 1;
        #1;
        check("t1_rst_grant", grant_o, 0);
        check("t1_rst_cyc", s_cyc_o, 0);
        check("t1_rst_stb", s_stb_o, 0);
        check("t1_rst_ack", m_ack_o, 0);
        rst = 0;
        s_ack = 0;
        model_reset();
        step();
        #1;
        check("t1_regrant", grant_o, 3'b001);
        m_cyc = '0; m_stb = '0;
        step();
        step();

        // Simultaneous request with pointer 0: 01 -> 00 -> 10.
        do_reset();
        m_cyc[1:0] = 2'b11; m_stb[1:0] = 2'b11;
        step();
        s_ack = 1;
        #1;
        check("t3_first", grant_o, 3'b001);
        check("t3_ack0", m_ack_o, 3'b001);
        step();
        m_cyc[0] = 0; m_stb[0] = 0; s_ack = 0;
        step();
        #1;
        check("t3_idle_gap", grant_o, 3'b000);
        step();
        #1;
        check("t3_second", grant_o, 3'b010);
        s_ack = 1;
        step();
        m_cyc[1] = 0; m_stb[1] = 0; s_ack = 0;
        step();
        step();

        // Burst lock: 8-beat incrementing burst on M0 while M1 waits.
        m_cyc[1:0] = 2'b11; m_stb[1:0] = 2'b11;
        m_cti[0 +: 3] = 3'b010;
        m_adr[0 +: AW] = 32'h0000_1000;
        step();
        acks0 = 0;
        acks1 = 0;
        for (int b = 0; b < 8; b++) begin
            m_adr[0 +: AW] = 32'h0000_1000 + 32'(4 * b);
            m_cti[0 +: 3] = (b == 7) ? 3'b111 : 3'b010;
            s_ack = 1;
            #1;
            check("t4_cti", s_cti_o, (b == 7) ? 3'b111 : 3'b010);
            acks0 += int'(m_ack_o[0]);
            acks1 += int'(m_ack_o[1]);
            step();
        end
        m_cyc[0] = 0; m_stb[0] = 0; s_ack = 0;
        #1;
        acks1 += int'(m_ack_o[1]);
        step();
        #1;
        check("t4_gap", grant_o, 0);
        step();
        s_ack = 1;
        #1;
        check("t4_m1_ack", m_ack_o, 3'b010);
        check("t4_acks0", acks0, 8);
        check("t4_acks1", acks1, 0);
        step();
        m_cyc[1] = 0; m_stb[1] = 0; s_ack = 0;
        step();
        step();

        // Fairness: all three request continuously with single beats.
        do_reset();
        acked = '0;
        seen = 0;
        prev_gnt = 0;
        for (int c = 0; c < 200 && seen < 6; c++) begin
            for (int k = 0; k < N; k++) begin
                if (acked[k]) begin
                    m_cyc[k] = 0; m_stb[k] = 0;
                end else if (!m_cyc[k]) begin
                    m_cyc[k] = 1; m_stb[k] = 1;
                end
            end
            #1;
            s_ack = s_stb_o;
            #1;
            acked = m_ack_o;
            if (grant_o != 0 && prev_gnt == 0) begin
                idx = 0;
                for (int k = 0; k < N; k++) if (grant_o[k]) idx = k;
                seq[seen] = idx;
                seen++;
            end
            prev_gnt = int'(grant_o);
            step();
        end
        check("t5_tenures", seen, 6);
        for (int i = 0; i < 6; i++) check("t5_order", seq[i], i % N);
        m_cyc = '0; m_stb = '0; s_ack = 0;
        step();
        step();

        // Hung slave on M0.
        do_reset();
        m_cyc[0] = 1; m_stb[0] = 1;
        step();
        errs = 0;
        first_err = 0;
        bad_cyc = 0;
`ifdef WB_ARB_TIMEOUT_EN
        n_cycles = 40;
`else
        n_cycles = 1000;
`endif
        for (int i = 1; i <= n_cycles; i++) begin
`ifdef WB_ARB_TIMEOUT_EN
            s_ack = (i == 20);
            #1;
            if (s_cyc_o !== ((i < TO) ? 1'b1 : 1'b0)) bad_cyc++;
`else
            #1;
            if (s_cyc_o !== 1'b1) bad_cyc++;
`endif
            if (m_err_o[0]) begin
                errs++;
                if (first_err == 0) first_err = i;
            end
            step();
        end
        s_ack = 0;
`ifdef WB_ARB_TIMEOUT_EN
        check("t6_err_count", errs, 1);
        check("t6_err_cycle", first_err, TO);
`else
        check("t6_no_err", errs, 0);
`endif
        check("t6_cyc_shape", bad_cyc, 0);
        m_cyc = '0; m_stb = '0;
        step();
        #1;
        check("t6_released", grant_o, 0);
        step();

        // Randomized traffic against the model, with one asynchronous reset.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (m_cyc[k]) begin
                    if ($urandom_range(7) == 0) m_cyc[k] = 0;
                end else if ($urandom_range(2) == 0) begin
                    m_cyc[k] = 1;
                end
                m_stb[k] = ($urandom_range(3) != 0);
                m_we[k]  = 1'($urandom_range(1));
                m_adr[k*AW +: AW] = $urandom;
                m_dat[k*DW +: DW] = $urandom;
                m_sel[k*SW +: SW] = 4'($urandom_range(15));
                m_cti[k*3 +: 3]   = 3'($urandom_range(7));
                m_bte[k*2 +: 2]   = 2'($urandom_range(3));
            end
            s_ack = 1'($urandom_range(1));
            s_err = ($urandom_range(15) == 0);
            s_dat = $urandom;
            if (c == 1500) begin
                #2 rst = 1;
                #1;
                check("rnd_rst_grant", grant_o, 0);
                check("rnd_rst_cyc", s_cyc_o, 0);
                rst = 0;
                model_reset();
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
Round-robin Wishbone B3 arbiter that shares one slave port (the SDRAM controller Wishbone port) between NUM_MASTERS requesters, e.g. the CPU instruction/data port and a DMA/debug master.
- Sits between the masters and the SDRAM controller in the SoC top, in the wb_clk domain.
- A grant is held for a master's whole cyc assertion, so bursts and locked sequences are never split.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
AW, 32, address width
DW, 32, data width; select width is DW/8
TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with WB_ARB_TIMEOUT_EN)

Ports:
wb_clk_i  in  1  Wishbone clock
wb_rst_i  in  1  reset, asynchronous, active-high
m_adr_i  in  NUM_MASTERS*AW  master addresses, master k at [k*AW +: AW]
m_dat_i  in  NUM_MASTERS*DW  master write data
m_sel_i  in  NUM_MASTERS*DW/8  byte selects
m_we_i  in  NUM_MASTERS  write enables
m_cyc_i  in  NUM_MASTERS  cycle requests
m_stb_i  in  NUM_MASTERS  strobes
m_cti_i  in  NUM_MASTERS*3  cycle type
m_bte_i  in  NUM_MASTERS*2  burst type
m_dat_o  out  DW  read data, broadcast to all masters
m_ack_o  out  NUM_MASTERS  per-master ack
m_err_o  out  NUM_MASTERS  per-master err
s_adr_o  out  AW  slave address
s_dat_o  out  DW  slave write data
s_sel_o  out  DW/8  slave select
s_we_o  out  1  slave write enable
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_cti_o  out  3  slave cycle type
s_bte_o  out  2  slave burst type
s_dat_i  in  DW  slave read data
s_ack_i  in  1  slave ack
s_err_i  in  1  slave err
grant_o  out  NUM_MASTERS  one-hot current grant, 0 when idle

Behaviour:
- FSM has two states. IDLE: no grant. BUSY: exactly one grant bit set.
- Reset (asynchronous, any time, including mid-burst):
  - state=IDLE, grant_o=0, priority pointer=0.
  - s_cyc_o=s_stb_o=0; m_ack_o=m_err_o=0.
  - Any in-flight slave transfer is abandoned.
- IDLE → BUSY:
  - Taken on the first edge where any m_cyc_i is high.
  - Winner is the first master with cyc high, searching from the pointer upward with wrap (pointer, pointer+1, …, NUM_MASTERS-1, 0, …).
  - Arbitration latency is one cycle: the slave sees the request on the cycle after cyc rises.
- BUSY:
  - Slave outputs are combinational muxes of the granted master's signals.
  - s_cyc_o = m_cyc_i[g]; s_stb_o = m_stb_i[g] & m_cyc_i[g].
  - m_ack_o[g]=s_ack_i and m_err_o[g]=s_err_i; all other ack/err bits are 0.
  - m_dat_o = s_dat_i in all states.
- BUSY → IDLE:
  - Taken on the edge where m_cyc_i[g] is low.
  - s_cyc_o falls in the same cycle as the master's cyc (combinational).
  - pointer ← (g+1) mod NUM_MASTERS.
  - At least one IDLE cycle always separates grants; no back-to-back hand-over in the same cycle.
- While IDLE: all slave outputs are 0; no ack/err reaches any master.
- Non-granted masters: requests are stalled (no ack) without limit, and their inputs are ignored.
- A master dropping cyc mid-burst ends the burst; the slave sees cyc low, as per Wishbone.
- Fairness: if all masters request continuously, grants rotate 0,1,…,N-1,0. No master waits more than NUM_MASTERS-1 tenures.
- NUM_MASTERS is not a power of two: the pointer wraps explicitly at NUM_MASTERS-1.

Optional Feature:
Macro WB_ARB_TIMEOUT_EN.
- Defined: a counter runs while BUSY & s_stb_o & !s_ack_i & !s_err_i and clears on ack, err, or leaving BUSY.
  - When it reaches TIMEOUT_CYCLES-1, the arbiter asserts m_err_o[g] for exactly one cycle and forces s_cyc_o=s_stb_o=0 in that cycle.
  - It then drops s_cyc_o/s_stb_o, remains BUSY with slave outputs gated off until m_cyc_i[g] falls, then returns to IDLE.
  - A late s_ack_i after the timeout is discarded.
- Undefined: no counter, no generated err; a hung slave stalls the granted master indefinitely.

Test Plan:
1. Reset mid-transfer: M0 granted, strobe pending; assert wb_rst_i for 1 ns → grant_o=0, s_cyc_o=0 immediately; after release, next grant goes to M0 (pointer=0).
2. Single master: M1 single write to 0x0000_0100, data 0xDEADBEEF, slave acks after 3 cycles → s_cyc_o rises 1 cycle after m_cyc_i[1]; m_ack_o=2'b10 for one cycle; m_ack_o[0] never set.
3. Simultaneous request from IDLE with pointer=0: M0 and M1 both raise cyc → M0 granted first; after M0 drops cyc, 1 IDLE cycle, then M1 granted (grant_o 01→00→10).
4. Burst lock: M0 issues an 8-beat incrementing burst (cti=010, last beat 111) while M1 requests → all 8 acks go to M0 and M1 receives no ack until M0's cyc falls.
5. Fairness with NUM_MASTERS=3, all requesting continuously with single-beat cycles → grant sequence 0,1,2,0,1,2.
6. WB_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16: slave never acks → m_err_o[g] pulses exactly once, 16 cycles after stb is first presented, and s_cyc_o=0 from that cycle on. Without the macro, the same stimulus → no err over 1000 cycles.
